// File: rtl/adc_pll_ctrl_pkg.sv
// Shared types and parameter defaults for the ADC PLL lock controller.
// The lock-sequence states and the counter sizing helper live here.
package adc_pll_ctrl_pkg;

    typedef enum logic [2:0] {
        PLL_RST,
        WAIT_LOCK,
        STABLE,
        RUN,
        FAULT
    } state_e;

    localparam int unsigned RST_CYCLES_DEF    = 16;
    localparam int unsigned LOCK_TIMEOUT_DEF  = 4096;
    localparam int unsigned STABLE_CYCLES_DEF = 256;
    localparam int unsigned MAX_RETRIES_DEF   = 3;

    localparam int unsigned LOSS_W   = 8;
    localparam logic [LOSS_W-1:0] LOSS_MAX = '1;

    // One timer is shared by every timed state, so it is sized for the longest interval.
    function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                         input int unsigned c);
        int unsigned m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/adc_pll_lock_ctrl_if.sv
// Status/control bundle between the PLL lock controller and its environment.
// slave is the controller side, master is the side that owns the PLL and consumes status.
interface adc_pll_lock_ctrl_if #(
    parameter int unsigned RTY_W = 2
);
    import adc_pll_ctrl_pkg::*;

    logic              pll_locked;
    logic              restart;
    logic              pll_rst;
    logic              adc_rst;
    logic              ready;
    logic              fault;
    logic [RTY_W-1:0]  retry_cnt;
    logic [LOSS_W-1:0] loss_cnt;

    modport master (
        output pll_locked, restart,
        input  pll_rst, adc_rst, ready, fault, retry_cnt, loss_cnt
    );

    modport slave (
        input  pll_locked, restart,
        output pll_rst, adc_rst, ready, fault, retry_cnt, loss_cnt
    );

endinterface

// File: rtl/adc_pll_lock_sync.sv
// Two-flop synchronizer bringing the PLL's raw lock flag into the refclk domain.
module adc_pll_lock_sync (
    input  logic clk_i,
    input  logic rst_i,
    input  logic async_i,
    output logic sync_o
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= async_i;
            sync_q <= meta_q;
        end
    end

    assign sync_o = sync_q;

endmodule

// File: rtl/adc_pll_lock_ctrl.sv
// Sequences the ADC PLL: reset pulse, wait for lock, qualify lock stability, run,
// and retry on lock timeouts until a fault is declared.
module adc_pll_lock_ctrl
    import adc_pll_ctrl_pkg::*;
#(
    parameter int unsigned RST_CYCLES    = RST_CYCLES_DEF,
    parameter int unsigned LOCK_TIMEOUT  = LOCK_TIMEOUT_DEF,
    parameter int unsigned STABLE_CYCLES = STABLE_CYCLES_DEF,
    parameter int unsigned MAX_RETRIES   = MAX_RETRIES_DEF
) (
    input  logic                               refclk,
    input  logic                               rst,
    input  logic                               pll_locked,
    input  logic                               restart,
    output logic                               pll_rst,
    output logic                               adc_rst,
    output logic                               ready,
    output logic                               fault,
    output logic [$clog2(MAX_RETRIES+1)-1:0]   retry_cnt,
    output logic [LOSS_W-1:0]                  loss_cnt
);

    localparam int unsigned TMR_W = $clog2(max3(RST_CYCLES, LOCK_TIMEOUT, STABLE_CYCLES) + 1);
    localparam int unsigned RTY_W = $clog2(MAX_RETRIES + 1);

    localparam logic [TMR_W-1:0] RST_LAST = TMR_W'(RST_CYCLES - 1);
    localparam logic [TMR_W-1:0] TMO_LAST = TMR_W'(LOCK_TIMEOUT - 1);
    localparam logic [TMR_W-1:0] STB_LAST = TMR_W'(STABLE_CYCLES - 1);
    localparam logic [RTY_W-1:0] RTY_LAST = RTY_W'(MAX_RETRIES - 1);

    state_e            state_q, state_d;
    logic [TMR_W-1:0]  tmr_q, tmr_d;
    logic [RTY_W-1:0]  retry_q, retry_d;
    logic [LOSS_W-1:0] loss_q, loss_d;
    logic              pll_rst_q, pll_rst_d;
    logic              adc_rst_q, adc_rst_d;
    logic              ready_q, ready_d;
    logic              fault_q, fault_d;
    logic              lock_s;

    adc_pll_lock_sync u_sync (
        .clk_i   (refclk),
        .rst_i   (rst),
        .async_i (pll_locked),
        .sync_o  (lock_s)
    );

    always_comb begin
        state_d = state_q;
        tmr_d   = tmr_q;
        retry_d = retry_q;
        loss_d  = loss_q;

        unique case (state_q)
            PLL_RST: begin
                if (tmr_q == RST_LAST) begin
                    state_d = WAIT_LOCK;
                    tmr_d   = '0;
                end else begin
                    tmr_d = tmr_q + 1'b1;
                end
            end
            // Lock takes priority over a timeout landing on the same cycle.
            WAIT_LOCK: begin
                if (lock_s) begin
                    state_d = STABLE;
                    tmr_d   = '0;
                end else if (tmr_q == TMO_LAST) begin
                    tmr_d   = '0;
                    retry_d = retry_q + 1'b1;
                    state_d = (retry_q == RTY_LAST) ? FAULT : PLL_RST;
                end else begin
                    tmr_d = tmr_q + 1'b1;
                end
            end
            STABLE: begin
                if (!lock_s) begin
                    state_d = WAIT_LOCK;
                    tmr_d   = '0;
                end else if (tmr_q == STB_LAST) begin
                    state_d = RUN;
                    tmr_d   = '0;
                    retry_d = '0;
                end else begin
                    tmr_d = tmr_q + 1'b1;
                end
            end
            RUN: begin
                if (!lock_s) begin
                    state_d = PLL_RST;
                    tmr_d   = '0;
                    if (loss_q != LOSS_MAX) begin
                        loss_d = loss_q + 1'b1;
                    end
                end
            end
            FAULT: begin
                state_d = FAULT;
            end
            default: begin
                state_d = PLL_RST;
                tmr_d   = '0;
            end
        endcase

        // A restart overrides the sequence but leaves the loss count to the RUN branch above.
        if (restart) begin
            state_d = PLL_RST;
            tmr_d   = '0;
            retry_d = '0;
        end

        pll_rst_d = (state_d == PLL_RST) || (state_d == FAULT);
        adc_rst_d = (state_d != RUN);
        ready_d   = (state_d == RUN);
        fault_d   = (state_d == FAULT);
    end

    always_ff @(posedge refclk) begin
        if (rst) begin
            state_q   <= PLL_RST;
            tmr_q     <= '0;
            retry_q   <= '0;
            loss_q    <= '0;
            pll_rst_q <= 1'b1;
            adc_rst_q <= 1'b1;
            ready_q   <= 1'b0;
            fault_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            tmr_q     <= tmr_d;
            retry_q   <= retry_d;
            loss_q    <= loss_d;
            pll_rst_q <= pll_rst_d;
            adc_rst_q <= adc_rst_d;
            ready_q   <= ready_d;
            fault_q   <= fault_d;
        end
    end

    assign pll_rst   = pll_rst_q;
    assign adc_rst   = adc_rst_q;
    assign ready     = ready_q;
    assign fault     = fault_q;
    assign retry_cnt = retry_q;
    assign loss_cnt  = loss_q;

endmodule

// File: tb/tb_adc_pll_lock_ctrl.sv
// Directed bench for the ADC PLL lock controller with shortened timing parameters.
module tb_adc_pll_lock_ctrl;

    localparam int unsigned RTY_W = 2;
    localparam int S_PLLRST = 0;
    localparam int S_READY  = 1;
    localparam int S_FAULT  = 2;

    logic refclk;
    logic rst;
    int   vec_cnt;
    int   miscmp_cnt;
    int   n;

    adc_pll_lock_ctrl_if #(.RTY_W(RTY_W)) bus ();

    adc_pll_lock_ctrl #(
        .RST_CYCLES    (4),
        .LOCK_TIMEOUT  (32),
        .STABLE_CYCLES (8),
        .MAX_RETRIES   (2)
    ) dut (
        .refclk     (refclk),
        .rst        (rst),
        .pll_locked (bus.pll_locked),
        .restart    (bus.restart),
        .pll_rst    (bus.pll_rst),
        .adc_rst    (bus.adc_rst),
        .ready      (bus.ready),
        .fault      (bus.fault),
        .retry_cnt  (bus.retry_cnt),
        .loss_cnt   (bus.loss_cnt)
    );

    initial refclk = 1'b0;
    always #5 refclk = ~refclk;

    task automatic chk(input string tag, input int act, input int exp);
        vec_cnt++;
        if (act !== exp) begin
            miscmp_cnt++;
            $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
        end
    endtask

    task automatic step(input int cycles);
        repeat (cycles) @(posedge refclk);
        #1;
    endtask

    function automatic logic sig(input int s);
        case (s)
            S_PLLRST: return bus.pll_rst;
            S_READY:  return bus.ready;
            default:  return bus.fault;
        endcase
    endfunction

    // Counts cycles until the selected output reaches v; gives up after maxc cycles.
    task automatic wait_sig(input int s, input logic v, input int maxc, output int cycles);
        cycles = 0;
        while (sig(s) !== v && cycles < maxc) begin
            step(1);
            cycles++;
        end
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_pll_rst"}, int'(bus.pll_rst), 1);
        chk({tag, "_adc_rst"}, int'(bus.adc_rst), 1);
        chk({tag, "_ready"},   int'(bus.ready),   0);
        chk({tag, "_fault"},   int'(bus.fault),   0);
        chk({tag, "_retry"},   int'(bus.retry_cnt), 0);
        chk({tag, "_loss"},    int'(bus.loss_cnt),  0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vec_cnt        = 0;
        miscmp_cnt     = 0;
        rst            = 1'b1;
        bus.pll_locked = 1'b0;
        bus.restart    = 1'b0;
        step(3);
        chk_reset_vals("por");
        rst = 1'b0;

        // Nominal bring-up
        wait_sig(S_PLLRST, 1'b0, 50, n);
        chk("nom_pllrst_w", n, 4);
        chk("nom_adc_rst_wait", int'(bus.adc_rst), 1);
        step(10);
        bus.pll_locked = 1'b1;
        wait_sig(S_READY, 1'b1, 50, n);
        chk("nom_ready_lat", n, 11);
        chk("nom_adc_rst", int'(bus.adc_rst), 0);
        chk("nom_retry", int'(bus.retry_cnt), 0);

        // Lock loss in RUN
        bus.pll_locked = 1'b0;
        wait_sig(S_READY, 1'b0, 20, n);
        chk("loss_lat", n, 3);
        chk("loss_adc_rst", int'(bus.adc_rst), 1);
        chk("loss_cnt1", int'(bus.loss_cnt), 1);
        chk("loss_pll_rst", int'(bus.pll_rst), 1);
        wait_sig(S_PLLRST, 1'b0, 20, n);
        chk("loss_pllrst_w", n, 4);

        // Lock glitch inside the stable window
        bus.pll_locked = 1'b1;
        step(5);
        bus.pll_locked = 1'b0;
        step(1);
        bus.pll_locked = 1'b1;
        wait_sig(S_READY, 1'b1, 50, n);
        chk("glitch_ready_lat", n, 11);
        chk("glitch_retry", int'(bus.retry_cnt), 0);

        // Restart coincident with lock loss
        bus.pll_locked = 1'b0;
        step(2);
        bus.restart = 1'b1;
        step(1);
        bus.restart = 1'b0;
        chk("rl_loss_cnt", int'(bus.loss_cnt), 2);
        chk("rl_ready", int'(bus.ready), 0);
        chk("rl_pll_rst", int'(bus.pll_rst), 1);
        wait_sig(S_PLLRST, 1'b0, 20, n);
        chk("rl_pllrst_w", n, 4);

        // Timeouts to FAULT
        wait_sig(S_PLLRST, 1'b1, 100, n);
        chk("tmo1_lat", n, 32);
        chk("tmo1_retry", int'(bus.retry_cnt), 1);
        chk("tmo1_fault", int'(bus.fault), 0);
        wait_sig(S_PLLRST, 1'b0, 20, n);
        chk("tmo1_pllrst_w", n, 4);
        wait_sig(S_FAULT, 1'b1, 100, n);
        chk("tmo2_lat", n, 32);
        chk("tmo2_retry", int'(bus.retry_cnt), 2);
        chk("tmo2_pll_rst", int'(bus.pll_rst), 1);
        chk("tmo2_adc_rst", int'(bus.adc_rst), 1);
        chk("tmo2_ready", int'(bus.ready), 0);
        step(40);
        chk("fault_hold", int'(bus.fault), 1);

        // Restart out of FAULT
        bus.restart = 1'b1;
        step(1);
        bus.restart = 1'b0;
        chk("rec_fault", int'(bus.fault), 0);
        chk("rec_retry", int'(bus.retry_cnt), 0);
        chk("rec_pll_rst", int'(bus.pll_rst), 1);
        wait_sig(S_PLLRST, 1'b0, 20, n);
        chk("rec_pllrst_w", n, 4);

        // Lock arriving on the timeout cycle wins
        step(29);
        bus.pll_locked = 1'b1;
        step(3);
        chk("race_pll_rst", int'(bus.pll_rst), 0);
        chk("race_retry", int'(bus.retry_cnt), 0);
        wait_sig(S_READY, 1'b1, 20, n);
        chk("race_ready_lat", n, 8);

        // Reset in the middle of RUN
        chk("pre_rst_loss", int'(bus.loss_cnt), 2);
        rst = 1'b1;
        bus.pll_locked = 1'b0;
        step(1);
        chk_reset_vals("midrst");
        rst = 1'b0;
        wait_sig(S_PLLRST, 1'b0, 50, n);
        chk("midrst_pllrst_w", n, 4);
        step(10);
        bus.pll_locked = 1'b1;
        wait_sig(S_READY, 1'b1, 50, n);
        chk("midrst_ready_lat", n, 11);

        // Loss counter saturation
        for (int i = 0; i < 300; i++) begin
            bus.pll_locked = 1'b0;
            wait_sig(S_READY, 1'b0, 20, n);
            bus.pll_locked = 1'b1;
            wait_sig(S_READY, 1'b1, 40, n);
            if (i == 0)   chk("sat_loss_first", int'(bus.loss_cnt), 1);
            if (i == 254) chk("sat_loss_255", int'(bus.loss_cnt), 255);
        end
        chk("sat_loss_300", int'(bus.loss_cnt), 255);
        chk("sat_ready", int'(bus.ready), 1);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miscmp_cnt);
        $finish;
    end

endmodule
